// File: rtl/adc_spi_pkg.sv
// Shared constants and types for the SPI ADC responder (8-channel, 12-bit ADC emulation).
package adc_spi_pkg;

   localparam int NUM_CH      = 8;
   localparam int DATA_W      = 12;
   localparam int FRAME_BITS  = 16;
   localparam int SYNC_STAGES = 2;
   localparam int ADDR_W      = $clog2(NUM_CH);
   localparam int CNT_W       = $clog2(FRAME_BITS);
   localparam int LEAD_W      = FRAME_BITS - DATA_W;

   // Counter values (before increment) of SCLK rising edges 3..5, which carry ADD2..ADD0.
   localparam logic [CNT_W-1:0] ADDR_FIRST_CNT = CNT_W'(2);
   localparam logic [CNT_W-1:0] ADDR_LAST_CNT  = CNT_W'(2 + ADDR_W - 1);
   localparam logic [CNT_W-1:0] LAST_CNT       = CNT_W'(FRAME_BITS - 1);

   typedef enum logic {IDLE, ACTIVE} state_t;

endpackage

// File: rtl/sync_edge_det.sv
// Multi-flop synchronizer for an asynchronous pin, with rise/fall pulses from the synchronized level.
module sync_edge_det #(
   parameter int SYNC_STAGES = 2,
   parameter bit RESET_VAL   = 1'b0
) (
   input  logic clk,
   input  logic rst_n,
   input  logic din,
   output logic level,
   output logic rise,
   output logic fall
);

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   prev_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q <= {SYNC_STAGES{RESET_VAL}};
         prev_q <= RESET_VAL;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], din};
         prev_q <= sync_q[SYNC_STAGES-1];
      end
   end

   assign level = sync_q[SYNC_STAGES-1];
   assign rise  = level & ~prev_q;
   assign fall  = ~level & prev_q;

endmodule

// File: rtl/adc_spi_responder.sv
// ADC-side SPI responder: returns the committed channel's sample as a 16-bit frame and
// captures the 3-bit channel address for the next frame from SADDR.
module adc_spi_responder
   import adc_spi_pkg::*;
(
   input  logic                     CLOCK_50,
   input  logic                     reset_n,
   input  logic                     adc_cs_n,
   input  logic                     adc_sclk,
   input  logic                     adc_saddr,
   output logic                     adc_sdat,
   output logic                     adc_sdat_oe,
   input  logic [NUM_CH*DATA_W-1:0] ch_data,
   output logic [ADDR_W-1:0]        cur_ch,
   output logic                     frame_done
);

   logic cs_lvl, cs_rise, cs_fall;
   logic sclk_lvl, sclk_rise, sclk_fall;
   logic saddr_lvl, saddr_rise, saddr_fall;
   logic unused_sync;

   // CS_N and SCLK idle high, so their synchronizers come out of reset high to avoid false edges.
   sync_edge_det #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_cs (
      .clk(CLOCK_50), .rst_n(reset_n), .din(adc_cs_n),
      .level(cs_lvl), .rise(cs_rise), .fall(cs_fall));

   sync_edge_det #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sclk (
      .clk(CLOCK_50), .rst_n(reset_n), .din(adc_sclk),
      .level(sclk_lvl), .rise(sclk_rise), .fall(sclk_fall));

   sync_edge_det #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_saddr (
      .clk(CLOCK_50), .rst_n(reset_n), .din(adc_saddr),
      .level(saddr_lvl), .rise(saddr_rise), .fall(saddr_fall));

   assign unused_sync = &{1'b0, cs_lvl, sclk_lvl, saddr_rise, saddr_fall};

   logic [DATA_W-1:0] ch_arr [NUM_CH];
   for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
      assign ch_arr[k] = ch_data[k*DATA_W +: DATA_W];
   end

   state_t                state_q, state_d;
   logic [CNT_W-1:0]      cnt_q, cnt_d;
   logic [FRAME_BITS-1:0] shreg_q, shreg_d;
   logic [ADDR_W-1:0]     pend_q, pend_d;
   logic [ADDR_W-1:0]     commit_q, commit_d;
   logic [ADDR_W-1:0]     cur_ch_q, cur_ch_d;
   logic                  oe_q, oe_d;
   logic                  done_q, done_d;
   logic                  armed_q, armed_d;
   logic [FRAME_BITS-1:0] sel_word;

   assign sel_word = {{LEAD_W{1'b0}}, ch_arr[commit_q]};

   always_ff @(posedge CLOCK_50 or negedge reset_n) begin
      if (!reset_n) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         shreg_q  <= '0;
         pend_q   <= '0;
         commit_q <= '0;
         cur_ch_q <= '0;
         oe_q     <= 1'b0;
         done_q   <= 1'b0;
         armed_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         shreg_q  <= shreg_d;
         pend_q   <= pend_d;
         commit_q <= commit_d;
         cur_ch_q <= cur_ch_d;
         oe_q     <= oe_d;
         done_q   <= done_d;
         armed_q  <= armed_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      shreg_d  = shreg_q;
      pend_d   = pend_q;
      commit_d = commit_q;
      cur_ch_d = cur_ch_q;
      oe_d     = oe_q;
      done_d   = 1'b0;
      armed_d  = armed_q;
      case (state_q)
         IDLE: begin
            if (cs_fall) begin
               state_d  = ACTIVE;
               shreg_d  = sel_word;
               cur_ch_d = commit_q;
               oe_d     = 1'b1;
               cnt_d    = '0;
               pend_d   = '0;
               armed_d  = 1'b0;
            end
         end
         ACTIVE: begin
            if (cs_rise) begin
               // Abandoned partial frames lose their pending address; the committed one stays.
               state_d = IDLE;
               oe_d    = 1'b0;
               shreg_d = '0;
               cnt_d   = '0;
               pend_d  = '0;
               armed_d = 1'b0;
            end else if (sclk_rise) begin
               if (cnt_q >= ADDR_FIRST_CNT && cnt_q <= ADDR_LAST_CNT)
                  pend_d = {pend_q[ADDR_W-2:0], saddr_lvl};
               if (cnt_q == LAST_CNT) begin
                  cnt_d    = '0;
                  commit_d = pend_q;
                  done_d   = 1'b1;
                  armed_d  = 1'b1;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end else if (sclk_fall) begin
               // The falling edge leading a selection (counter 0, nothing completed) is ignored.
               if (cnt_q != '0) begin
                  shreg_d = {shreg_q[FRAME_BITS-2:0], 1'b0};
               end else if (armed_q) begin
                  shreg_d  = sel_word;
                  cur_ch_d = commit_q;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign adc_sdat    = shreg_q[FRAME_BITS-1];
   assign adc_sdat_oe = oe_q;
   assign cur_ch      = cur_ch_q;
   assign frame_done  = done_q;

endmodule

// File: tb/tb_adc_spi_responder.sv
// Bench for adc_spi_responder: a bit-banged SPI master feeds a received-frame queue that a
// monitor checks against expectations from a channel/address model.
module tb_adc_spi_responder;

   logic        CLOCK_50 = 1'b0;
   logic        reset_n;
   logic        adc_cs_n;
   logic        adc_sclk;
   logic        adc_saddr;
   logic        adc_sdat;
   logic        adc_sdat_oe;
   logic [95:0] ch_data;
   logic [2:0]  cur_ch;
   logic        frame_done;

   adc_spi_responder dut (
      .CLOCK_50(CLOCK_50), .reset_n(reset_n), .adc_cs_n(adc_cs_n), .adc_sclk(adc_sclk),
      .adc_saddr(adc_saddr), .adc_sdat(adc_sdat), .adc_sdat_oe(adc_sdat_oe),
      .ch_data(ch_data), .cur_ch(cur_ch), .frame_done(frame_done));

   always #10 CLOCK_50 = ~CLOCK_50;

   typedef struct {
      logic [15:0] word;
      logic [2:0]  ch;
   } item_t;

   item_t       exp_q[$];
   item_t       rx_q[$];
   int          total = 0;
   int          bad = 0;
   int          done_cnt = 0;
   int          exp_done = 0;
   logic [2:0]  m_commit = 3'd0;
   int          chg_at = 0;
   logic [11:0] chg_val = 12'h000;
   logic        prev_done = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
      end
   endtask

   function automatic logic [11:0] ch_val(input int k);
      return ch_data[k*12 +: 12];
   endfunction

   // Every returned frame is compared with the oldest outstanding expectation.
   initial begin : monitor
      item_t e, r;
      forever begin
         @(negedge CLOCK_50);
         if (frame_done) begin
            done_cnt++;
            check("frame_done_width", {31'd0, prev_done}, 32'd0);
         end
         prev_done = frame_done;
         while (rx_q.size() > 0) begin
            r = rx_q.pop_front();
            check("exp_available", {31'd0, exp_q.size() > 0}, 32'd1);
            if (exp_q.size() > 0) begin
               e = exp_q.pop_front();
               check("frame_word", {16'd0, r.word}, {16'd0, e.word});
               check("frame_cur_ch", {29'd0, r.ch}, {29'd0, e.ch});
            end
         end
      end
   end

   initial begin : watchdog
      #5000000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "bench timed out");
   end

   task automatic cs_low();
      adc_cs_n = 1'b0;
      repeat (3) @(negedge CLOCK_50);
      check("oe_after_select", {31'd0, adc_sdat_oe}, 32'd1);
      check("sdat_bit15", {31'd0, adc_sdat}, 32'd0);
      repeat (3) @(negedge CLOCK_50);
   endtask

   task automatic cs_high();
      adc_cs_n = 1'b1;
      repeat (3) @(negedge CLOCK_50);
      check("oe_after_deselect", {31'd0, adc_sdat_oe}, 32'd0);
      check("sdat_after_deselect", {31'd0, adc_sdat}, 32'd0);
      repeat (5) @(negedge CLOCK_50);
      check("frame_done_count", done_cnt, exp_done);
   endtask

   // One SCLK cycle per bit: low phase then high phase; the master samples just before rising.
   task automatic run_frame(input logic [2:0] addr, input int nbits, input int phase);
      item_t       e, r;
      logic [15:0] w;
      if (nbits == 16) begin
         e.word = {4'h0, ch_val(int'(m_commit))};
         e.ch   = m_commit;
         exp_q.push_back(e);
      end
      w = '0;
      for (int i = 1; i <= nbits; i++) begin
         adc_sclk = 1'b0;
         if (i >= 3 && i <= 5) adc_saddr = addr[5-i];
         else adc_saddr = 1'($urandom_range(0, 1));
         if (i == chg_at) ch_data[11:0] = chg_val;
         repeat (phase) @(negedge CLOCK_50);
         w = {w[14:0], adc_sdat};
         adc_sclk = 1'b1;
         repeat (phase) @(negedge CLOCK_50);
      end
      if (nbits == 16) begin
         m_commit = addr;
         exp_done++;
         r.word = w;
         r.ch   = cur_ch;
         rx_q.push_back(r);
      end
   endtask

   initial begin : stimulus
      int nfr;
      int ph;
      reset_n   = 1'b0;
      adc_cs_n  = 1'b1;
      adc_sclk  = 1'b1;
      adc_saddr = 1'b0;
      ch_data   = '0;
      repeat (3) @(negedge CLOCK_50);
      check("reset_sdat", {31'd0, adc_sdat}, 32'd0);
      check("reset_oe", {31'd0, adc_sdat_oe}, 32'd0);
      check("reset_cur_ch", {29'd0, cur_ch}, 32'd0);
      check("reset_frame_done", {31'd0, frame_done}, 32'd0);
      reset_n = 1'b1;
      repeat (4) @(negedge CLOCK_50);

      // Single frame from channel 0.
      ch_data[0 +: 12] = 12'hABC;
      cs_low();
      run_frame(3'd0, 16, 8);
      cs_high();

      // Back-to-back: address 5 in frame 1 selects ch5 for frame 2.
      ch_data[5*12 +: 12] = 12'h123;
      cs_low();
      run_frame(3'd5, 16, 8);
      run_frame(3'd0, 16, 8);
      cs_high();

      // Partial frame carrying address 2 must not commit it.
      cs_low();
      run_frame(3'd2, 8, 8);
      cs_high();
      cs_low();
      run_frame(3'd0, 16, 8);
      cs_high();

      // Sample change mid-frame does not disturb the frame in flight.
      ch_data[0 +: 12] = 12'hFFF;
      chg_at  = 6;
      chg_val = 12'h000;
      cs_low();
      run_frame(3'd0, 16, 8);
      chg_at = 0;
      run_frame(3'd0, 16, 8);
      cs_high();

      // Asynchronous reset in the middle of a frame from channel 3.
      ch_data[3*12 +: 12] = 12'h3C3;
      ch_data[0 +: 12]    = 12'h5A5;
      cs_low();
      run_frame(3'd3, 16, 8);
      run_frame(3'd1, 9, 8);
      #7 reset_n = 1'b0;
      #1;
      check("async_reset_oe", {31'd0, adc_sdat_oe}, 32'd0);
      check("async_reset_cur_ch", {29'd0, cur_ch}, 32'd0);
      check("async_reset_sdat", {31'd0, adc_sdat}, 32'd0);
      m_commit = 3'd0;
      @(negedge CLOCK_50);
      adc_cs_n = 1'b1;
      repeat (2) @(negedge CLOCK_50);
      reset_n = 1'b1;
      repeat (6) @(negedge CLOCK_50);
      cs_low();
      run_frame(3'd0, 16, 8);
      cs_high();

      // Address sweep: each frame returns the channel addressed by the previous one.
      for (int k = 0; k < 8; k++) ch_data[k*12 +: 12] = 12'(12'h101 * k);
      cs_low();
      for (int k = 0; k < 8; k++) run_frame(3'(k), 16, 8);
      run_frame(3'd0, 16, 8);
      cs_high();

      // Randomized selections with random data, addresses, frame counts and SCLK rates.
      for (int s = 0; s < 8; s++) begin
         for (int k = 0; k < 8; k++) ch_data[k*12 +: 12] = 12'($urandom_range(0, 4095));
         nfr = $urandom_range(1, 3);
         ph  = $urandom_range(5, 9);
         cs_low();
         for (int f = 0; f < nfr; f++) run_frame(3'($urandom_range(0, 7)), 16, ph);
         cs_high();
      end

      repeat (10) @(negedge CLOCK_50);
      check("exp_queue_drained", exp_q.size(), 32'd0);
      check("final_frame_done_count", done_cnt, exp_done);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/adc_spi_responder.md
Name: adc_spi_responder

Overview:
- Synthesizable serial responder that emulates the on-board 8-channel, 12-bit SPI ADC, seen from the ADC side.
- Receives the chip-select, serial clock and address outputs of the IMU controller's ADC master and returns per-channel sample words on the ADC data line.
- Sits on a GPIO header for loopback and hardware-in-the-loop testing of the IMU controller without the physical ADC; sample values come from a parallel bus (Nios PIO or a test pattern generator).

Parameters:
- NUM_CH, 8, number of emulated channels; address field width is clog2(NUM_CH)=3.
- DATA_W, 12, sample width.
- FRAME_BITS, 16, SCLK cycles per conversion frame; leading zeros = FRAME_BITS-DATA_W.
- SYNC_STAGES, 2, synchronizer depth on CS_N, SCLK and SADDR.

Ports:
- CLOCK_50  in  1  system clock; all logic is on this single clock.
- reset_n  in  1  asynchronous active-low reset.
- adc_cs_n  in  1  chip select from the master (asynchronous to CLOCK_50).
- adc_sclk  in  1  serial clock from the master; idles high.
- adc_saddr  in  1  address bit from the master, sampled on SCLK rising edges.
- adc_sdat  out  1  serial data to the master, changes after SCLK falling edges.
- adc_sdat_oe  out  1  output enable for adc_sdat; high only while the chip is selected.
- ch_data  in  NUM_CH*DATA_W  sample values; channel k is at [k*DATA_W +: DATA_W].
- cur_ch  out  3  channel whose data is currently being shifted out.
- frame_done  out  1  one-cycle pulse after each complete 16-bit frame.

Behaviour:
- Reset values: adc_sdat=0, adc_sdat_oe=0, cur_ch=0, frame_done=0, committed address=0, bit counter=0, shift register=0.
- Input conditioning: all three inputs pass through SYNC_STAGES flops. Edge detect uses the synchronized value and its previous value. The pin-to-action latency is 3 CLOCK_50 cycles. SCLK high and low phases must each be at least 5 CLOCK_50 cycles (SCLK at most 5 MHz). Faster SCLK is out of scope and is not checked.
- States: IDLE, ACTIVE.
- IDLE -> ACTIVE on synchronized CS_N falling edge:
  - load shift register with {4'b0, ch_data[committed_addr]} (snapshot taken here);
  - cur_ch=committed_addr, adc_sdat=bit15 (0), adc_sdat_oe=1, bit counter=0.
- ACTIVE, SCLK rising edge:
  - counter increments.
  - Rising edges 3, 4 and 5 (counter 2, 3, 4 before increment) shift adc_saddr into the pending address, MSB first (ADD2, ADD1, ADD0).
  - On the 16th rising edge, counter wraps to 0, pending address becomes committed, and frame_done pulses the next cycle.
- ACTIVE, SCLK falling edge:
  - If counter != 0, shift left and drive the next bit, so bits 14..0 appear on falling edges 1..15.
  - If counter == 0 after at least one completed frame (the 16th falling edge), start a back-to-back frame. Reload from ch_data[committed_addr], cur_ch updates, drive bit15.
- ACTIVE -> IDLE on synchronized CS_N rising edge, at any point:
  - adc_sdat_oe=0 and adc_sdat=0 on the same cycle; counter=0.
  - A partial frame gives no frame_done and discards the pending address; the committed address is retained.
- CS_N falling and SCLK edge detected in the same cycle: the CS action takes priority and the SCLK edge is ignored.
- reset_n asserted mid-frame: all state goes to reset values immediately; adc_sdat_oe drops asynchronously.
- ch_data changes mid-frame do not affect the frame in flight.

Decomposition:
- Package adc_spi_pkg holds NUM_CH, DATA_W, FRAME_BITS, the ADDR_W=3 constant, address bit positions (rising edges 3..5), and the state enum {IDLE, ACTIVE}.
- Sub-module sync_edge_det (SYNC_STAGES flops plus rise/fall pulse outputs) is instantiated three times. The responder top holds the FSM, counter, shift register and address logic.

Test Plan:
- Reset, then CS_N low with ch_data ch0=12'hABC, 16 SCLK cycles at 3.125 MHz, SADDR=0 -> master samples 16'h0ABC on rising edges; frame_done pulses once; cur_ch=0.
- Back-to-back frames, CS_N held low: frame 1 sends addr 3'b101, ch5=12'h123 -> frame 2 returns 16'h0123 and cur_ch=5 from the 16th falling edge.
- CS_N deasserted after 8 SCLKs of a frame sending addr 3'b010 -> adc_sdat_oe=0 within 3 cycles, no frame_done; next selection returns the previous committed channel (0), not 2.
- ch0 changed from 12'hFFF to 12'h000 at SCLK 6 mid-frame -> frame still returns 16'h0FFF; the following frame returns 16'h0000.
- reset_n pulsed low during bit 9 -> adc_sdat_oe=0 asynchronously, cur_ch=0; a fresh CS_N frame afterwards returns ch0 correctly.
- Sweep all 8 addresses with ch_data[k]=12'h100*k+k -> each frame returns the value of the channel addressed in the previous frame.
